// File: rtl/multi_adc_sampler_pkg.sv
// Shared FSM state encoding, ADC command-word fields and frame-length constant
// for the multi-channel ADC sampler.
package multi_adc_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_PUSH
    } state_e;

    localparam logic [3:0] CMD_PREFIX = 4'b0001;
    localparam logic       CMD_SINGLE = 1'b1;
    localparam logic [1:0] CMD_PAD    = 2'b00;
    localparam logic [6:0] CMD_TAIL   = 7'b1000000;

    // Frame length in SCK half-periods: setup, 32 shift halves, hold
    localparam int FRAME_LEN = 34;

    function automatic logic [15:0] cmd_word(input logic [1:0] ch);
        return {CMD_PREFIX, CMD_SINGLE, CMD_PAD, ch, CMD_TAIL};
    endfunction

endpackage

// File: rtl/multi_adc_sampler_if.sv
// Sample FIFO bus: write side from the sequencer, read side to the host.
interface multi_adc_sampler_if #(parameter int DBITS = 16);

    logic             wr_en;
    logic [DBITS-1:0] wr_data;
    logic             rd_en;
    logic [DBITS-1:0] rd_data;
    logic             empty;
    logic             full;

    modport master (output wr_en, wr_data, rd_en, input rd_data, empty, full);
    modport slave  (input wr_en, wr_data, rd_en, output rd_data, empty, full);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered read data; a write while full is accepted
// when a read is accepted in the same cycle.
module sample_fifo #(
    parameter int abits = 13,
    parameter int dbits = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multi_adc_sampler_if.slave  bus
);

    localparam logic [abits:0] DEPTH = (abits + 1)'(2 ** abits);

    logic [dbits-1:0] mem_q [2 ** abits];
    logic [abits-1:0] wr_ptr_q, wr_ptr_d;
    logic [abits-1:0] rd_ptr_q, rd_ptr_d;
    logic [abits:0]   count_q, count_d;
    logic [dbits-1:0] rd_data_q, rd_data_d;
    logic             rd_ok;
    logic             wr_ok;

    always_comb begin
        rd_ok     = bus.rd_en && (count_q != '0);
        wr_ok     = bus.wr_en && ((count_q != DEPTH) || rd_ok);
        wr_ptr_d  = wr_ptr_q + abits'(wr_ok);
        rd_ptr_d  = rd_ptr_q + abits'(rd_ok);
        count_d   = count_q + (abits + 1)'(wr_ok) - (abits + 1)'(rd_ok);
        rd_data_d = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data = rd_data_q;
    assign bus.empty   = (count_q == '0);
    assign bus.full    = (count_q == DEPTH);

endmodule

// File: rtl/multi_adc_sampler.sv
// Round-robin SPI ADC sequencer feeding a sample FIFO.
// Define ADC_CH_TAG_EN to store {2'b00, tag, sample[11:0]} instead of the raw word.
module multi_adc_sampler
    import multi_adc_sampler_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int FIFO_ABITS    = 13,
    parameter int SCK_DIV       = 1,
    parameter int SAMPLE_PERIOD = 256
) (
    input  logic        SYS_CLK,
    input  logic        reset_n,
    input  logic        ENA,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SCK,
    output logic        CSbar,
    input  logic        RD,
    output logic [15:0] DOUT,
    output logic        EMPTY,
    output logic        FULL,
    output logic [7:0]  OVF_CNT,
    output logic        BUSY
);

    localparam int             TW      = $clog2(SAMPLE_PERIOD);
    localparam logic [TW-1:0]  TMAX    = TW'(SAMPLE_PERIOD - 1);
    localparam int             DW      = $clog2(SCK_DIV + 1);
    localparam logic [DW-1:0]  DMAX    = DW'(SCK_DIV - 1);
    localparam logic [1:0]     CH_LAST = 2'(NCH - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          csbar_q, csbar_d;
    logic          busy_q, busy_d;
    logic [15:0]   shift_q, shift_d;
    logic [1:0]    ch_q, ch_d;
    logic          ena_q, ena_d;
    logic          discard_q, discard_d;
    logic [7:0]    ovf_q, ovf_d;
`ifdef ADC_CH_TAG_EN
    logic [1:0]    tag_q, tag_d;
`endif

    logic [15:0]   cmd;
    logic          push_req;
    logic          drop;

    multi_adc_sampler_if #(.DBITS(16)) fifo_bus ();

    assign cmd      = cmd_word(ch_q);
    assign push_req = (state_q == ST_PUSH) && !discard_q;
    assign drop     = push_req && fifo_bus.full && !RD;

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q == TMAX) ? '0 : timer_q + TW'(1);
        div_d     = div_q;
        bit_d     = bit_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        shift_d   = shift_q;
        ch_d      = ch_q;
        ena_d     = ENA;
        discard_d = discard_q | (ENA & ~ena_q);
        ovf_d     = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
`ifdef ADC_CH_TAG_EN
        tag_d     = tag_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (timer_q == TMAX && ENA) begin
                    state_d = ST_CS_SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    mosi_d  = cmd[15];
                end
            end
            ST_CS_SETUP: begin
                if (div_q == DMAX) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            // Rising SCK samples MISO; falling SCK presents the next command bit
            ST_SHIFT: begin
                if (div_q == DMAX) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        shift_d = {shift_q[14:0], MISO};
                    end else if (bit_q == 4'd15) begin
                        state_d = ST_CS_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        mosi_d = cmd[4'd14 - bit_q];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_CS_HOLD: begin
                if (div_q == DMAX) begin
                    state_d = ST_PUSH;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ST_PUSH: begin
                state_d   = ST_IDLE;
                ch_d      = (ch_q == CH_LAST) ? 2'd0 : ch_q + 2'd1;
                discard_d = ENA & ~ena_q;
`ifdef ADC_CH_TAG_EN
                tag_d     = ch_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        csbar_d = !(state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge SYS_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            csbar_q   <= 1'b1;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            ch_q      <= '0;
            ena_q     <= 1'b0;
            discard_q <= 1'b1;
            ovf_q     <= '0;
`ifdef ADC_CH_TAG_EN
            tag_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            csbar_q   <= csbar_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            ch_q      <= ch_d;
            ena_q     <= ena_d;
            discard_q <= discard_d;
            ovf_q     <= ovf_d;
`ifdef ADC_CH_TAG_EN
            tag_q     <= tag_d;
`endif
        end
    end

    assign fifo_bus.wr_en = push_req;
    assign fifo_bus.rd_en = RD;
`ifdef ADC_CH_TAG_EN
    assign fifo_bus.wr_data = {2'b00, tag_q, shift_q[11:0]};
`else
    assign fifo_bus.wr_data = shift_q;
`endif

    sample_fifo #(
        .abits (FIFO_ABITS),
        .dbits (16)
    ) u_fifo (
        .clk   (SYS_CLK),
        .rst_n (reset_n),
        .bus   (fifo_bus)
    );

    assign MOSI    = mosi_q;
    assign SCK     = sck_q;
    assign CSbar   = csbar_q;
    assign BUSY    = busy_q;
    assign OVF_CNT = ovf_q;
    assign DOUT    = fifo_bus.rd_data;
    assign EMPTY   = fifo_bus.empty;
    assign FULL    = fifo_bus.full;

endmodule
